// File: rtl/branch_cdb.sv
// ---------------------------------------------------------------------------
// branch_cdb
//   Branch-result broadcast stage sitting behind the branch ALU reservation
//   station. Each resolved branch is captured into a small FIFO and its RS
//   entry is retired with a one-cycle finish pulse. The PC/fetch unit drains
//   outcomes, in capture order, through a valid/ready handshake.
//
//   Optional feature macro: BRANCH_CDB_STATS_EN
//     When defined, saturating 16-bit taken/total counters are built.
//     When undefined, stat_taken/stat_total are tied to zero.
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-low reset
//   alu_valid    : branch ALU result valid this cycle
//   alu_rsnum    : RS index of the result
//   alu_result   : 1 = branch taken
//   alu_offset   : branch offset carried by the RS entry
//   finish       : one-cycle retire pulse back to the branch ALU
//   finish_rsnum : RS index being retired (holds last value when idle)
//   pc_valid     : FIFO head valid
//   pc_ready     : PC unit accepts the head
//   pc_taken     : head taken flag (0 when empty)
//   pc_offset    : head PC increment (0 when empty)
//   pending      : FIFO non-empty or finish in flight
//   count        : FIFO occupancy
//   stat_taken   : taken-branch counter
//   stat_total   : resolved-branch counter
// ---------------------------------------------------------------------------
module branch_cdb #(
    parameter int RS_W   = 3,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [RS_W-1:0]            alu_rsnum,
    input  logic                       alu_result,
    input  logic [ADDR_W-1:0]          alu_offset,
    output logic                       finish,
    output logic [RS_W-1:0]            finish_rsnum,
    output logic                       pc_valid,
    input  logic                       pc_ready,
    output logic                       pc_taken,
    output logic [ADDR_W-1:0]          pc_offset,
    output logic                       pending,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                stat_taken,
    output logic [15:0]                stat_total
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] SEQ_INC = ADDR_W'(4);

    // Entry layout: {taken, offset}
    logic [ADDR_W:0]   mem [DEPTH];

    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic              finish_reg;
    logic [RS_W-1:0]   finish_rsnum_reg;

    logic [PTR_W:0]    count_int;
    logic              full;
    logic              empty;
    logic              pop;
    logic              dup;
    logic              push;
    logic [ADDR_W:0]   wr_entry;
    logic [ADDR_W:0]   head_entry;

    assign count_int = wr_ptr_reg - rd_ptr_reg;
    assign full      = (count_int == FULL_CNT);
    assign empty     = (count_int == '0);
    assign pop       = pc_valid & pc_ready;

    // A result matching the RS entry currently being retired is a
    // re-broadcast of something already captured; it must not be queued twice.
    assign dup  = finish_reg && (alu_rsnum == finish_rsnum_reg);

    // When full, a same-cycle pop frees the slot the push will reuse.
    assign push = alu_valid && (!full || pop) && !dup;

    // Not-taken branches advance the PC by one instruction.
    assign wr_entry = {alu_result, (alu_result ? alu_offset : SEQ_INC)};

    // ------------------------------------------------------------------
    // Pointers and finish pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            finish_reg       <= 1'b0;
            finish_rsnum_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            finish_reg <= push;
            if (push) begin
                finish_rsnum_reg <= alu_rsnum;
            end
        end
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= wr_entry;
        end
    end

    assign head_entry = mem[rd_ptr_reg[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_valid     = !empty;
    assign pc_taken     = empty ? 1'b0 : head_entry[ADDR_W];
    assign pc_offset    = empty ? '0 : head_entry[ADDR_W-1:0];
    assign finish       = finish_reg;
    assign finish_rsnum = finish_rsnum_reg;
    assign pending      = !empty || finish_reg;
    assign count        = count_int;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_CDB_STATS_EN
    logic [15:0] stat_taken_reg;
    logic [15:0] stat_total_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_taken_reg <= '0;
            stat_total_reg <= '0;
        end else if (push) begin
            if (stat_total_reg != 16'hFFFF) begin
                stat_total_reg <= stat_total_reg + 16'd1;
            end
            if (alu_result && (stat_taken_reg != 16'hFFFF)) begin
                stat_taken_reg <= stat_taken_reg + 16'd1;
            end
        end
    end

    assign stat_taken = stat_taken_reg;
    assign stat_total = stat_total_reg;
`else
    assign stat_taken = '0;
    assign stat_total = '0;
`endif

endmodule

// File: doc/branch_cdb.md
# branch_cdb

Branch-result broadcast stage directly downstream of the branch ALU reservation station. Captures each resolved branch (RS number, taken flag, offset), retires the RS entry via a one-cycle finish pulse, and queues the outcome in a small FIFO. The PC/fetch unit drains the FIFO through a valid/ready handshake. Outcomes are delivered in capture order.

## Interface
- `RS_W`, 3, width of branch RS index (matches `branchALURSWidth`)
- `ADDR_W`, 32, address/offset width (matches `addrWidth`)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `alu_valid` in 1: branch ALU result valid this cycle (`branchALUSignal`)
- `alu_rsnum` in RS_W: RS index of the result
- `alu_result` in 1: 1 = taken
- `alu_offset` in ADDR_W: branch offset from the RS entry
- `finish` out 1: retire pulse to branch ALU (`branchALUFinish`)
- `finish_rsnum` out RS_W: RS index being retired (`branchALU_CDB_RSnum`)
- `pc_valid` out 1: FIFO head valid
- `pc_ready` in 1: PC unit accepts head
- `pc_taken` out 1: head taken flag
- `pc_offset` out ADDR_W: PC increment for head
- `pending` out 1: FIFO non-empty or finish in flight (fetch stall hint)
- `count` out log2(DEPTH)+1: current occupancy
- `stat_taken` out 16: taken-branch counter (see Configuration)
- `stat_total` out 16: resolved-branch counter (see Configuration)

## Operation
- Storage: DEPTH entries of {taken, offset}; wr_ptr/rd_ptr with log2(DEPTH) bits plus wrap bit; count = wr_ptr − rd_ptr.
- Pop: when `pc_valid & pc_ready`, rd_ptr increments.
- Push condition: `alu_valid` and (count < DEPTH or pop this cycle) and not duplicate.
  - On push, write {alu_result, alu_result ? alu_offset : ADDR_W'd4} at wr_ptr, then increment wr_ptr.
- Duplicate rule: when `finish` is high and `alu_rsnum == finish_rsnum`, the input is a re-broadcast of an entry already being retired. Ignore it: no push, no finish.
- Full drop: when push is refused because the FIFO is full, drop the input and do not raise `finish`. The RS entry stays ready and the branch ALU re-broadcasts it, so no result is lost.
- Finish: registered.
  - A push at edge t drives `finish`=1 and `finish_rsnum`=alu_rsnum for exactly the cycle after edge t.
  - Otherwise `finish`=0 and `finish_rsnum` holds its last value.
- Head outputs: combinational from FIFO[rd_ptr].
  - `pc_valid` = (count ≠ 0).
  - `pc_taken` and `pc_offset` are 0 when empty.
- `pending` = (count ≠ 0) | `finish`.
- Offset arithmetic: no sign handling. The offset passes through unmodified; the PC unit adds it to the branch PC.

## Timing
- Reset (rst=0, asynchronous):
  - Pointers, count, `finish`, `finish_rsnum`, and stats clear to 0.
  - `pc_valid`=0, `pc_taken`=0, `pc_offset`=0, `pending`=0.
  - Entries in flight are discarded. A finish pulse that would have followed the reset edge is suppressed.
- Latency:
  - Input to `finish`: 1 cycle.
  - Input to `pc_valid` into an empty FIFO: 1 cycle.
  - Head change after pop: next cycle.
- Simultaneous push and pop:
  - count unchanged.
  - When full, the pop slot is reused in the same cycle.
  - When empty, no bypass: the pushed entry appears next cycle.
- Wrap-around: pointers wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- `pc_ready` without `pc_valid`: no effect.
- `pc_valid` stays high, with stable data, until accepted.

## Configuration
- `BRANCH_CDB_STATS_EN` defined:
  - `stat_total` increments on every push.
  - `stat_taken` increments on every push with alu_result=1.
  - Both saturate at 16'hFFFF and clear on reset.
- `BRANCH_CDB_STATS_EN` undefined: `stat_taken` and `stat_total` are tied to 0 and no counter logic is present.

## Test plan
- Reset then single push (rsnum=5, taken=1, offset=0x40):
  - Next cycle: `finish`=1, `finish_rsnum`=5, `pc_valid`=1, `pc_taken`=1, `pc_offset`=0x40.
  - `finish` drops the following cycle.
- Not-taken push (offset=0x80, result=0) -> `pc_offset`=4, `pc_taken`=0.
- Fill to DEPTH=4 with `pc_ready`=0, then push rsnum=2:
  - No `finish`, count stays 4.
  - Re-present rsnum=2 with `pc_ready`=1: accepted, `finish_rsnum`=2, count stays 4.
- Push rsnum=3, then re-present rsnum=3 in the cycle `finish` is high -> ignored, count increments only once.
- Six pushes interleaved with pops across the pointer wrap -> outcomes emerge in order with correct offsets.
- Assert rst=0 mid-stream with 3 entries queued -> outputs zero immediately; after release, count=0 and no `finish` pulse.
- With `BRANCH_CDB_STATS_EN`: 3 taken and 2 not-taken pushes -> `stat_taken`=3, `stat_total`=5.
